alu_exec_ctrl: RTL
==================

# alu_exec_ctrl

Execute-stage sequencer for the 16-bit ALU. It accepts one decoded instruction per valid/ready handshake and latches its operands. It drives the ALU's operand and `AluOp` inputs for one cycle, then captures the result and condition codes into the architectural CCR. The result is presented downstream to write-back or memory under a second valid/ready handshake. It sits between decode/register-read and write-back, and the ALU remains a purely combinational instance outside this block.

## Interface
Parameters:
- `WIDTH`, 16, datapath width
- `RADDR_W`, 3, register address width

Ports:
- `clk`  in  1  rising-edge clock; the block uses one clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  instruction offered
- `in_ready`  out  1  block can accept
- `in_op`  in  4  instruction class (see Operation)
- `in_rs_val`  in  WIDTH  Rs operand value
- `in_rd_val`  in  WIDTH  Rd operand value
- `in_imm`  in  WIDTH  immediate, used only by LDM
- `in_rd_addr`  in  RADDR_W  destination register
- `alu_rs`  out  WIDTH  to ALU Rs
- `alu_rd`  out  WIDTH  to ALU Rd
- `alu_op`  out  3  to ALU AluOp
- `alu_out`  in  WIDTH  from ALU Out
- `alu_ccr`  in  3  from ALU Ccr
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts
- `out_result`  out  WIDTH  captured result
- `out_rd_addr`  out  RADDR_W  destination register
- `out_wb_en`  out  1  register write-back required
- `out_mem_wr`  out  1  store (result is store data)
- `ccr`  out  3  architectural flags: [0]=Z, [1]=N, [2]=C
- `illegal`  out  1  one-cycle pulse when an undefined `in_op` is accepted

## Operation
- `in_op` encodings:
  - NOP=0
  - SETC=1
  - CLRC=2
  - NOT=3
  - ADD=4
  - LDM=5
  - STD=6
  - 7–15 illegal, executed as NOP
- ALU op mapping: NOP/SETC/CLRC→0, LDM→1, STD→2, ADD→3, NOT→4.
- Operand routing:
  - `alu_rs` = latched Rs.
  - `alu_rd` = latched imm for LDM, latched Rd otherwise.
- FSM states IDLE, EXEC, DONE.
  - IDLE: `in_ready`=1. On `in_valid`, latch op, operands and rd_addr, then go to EXEC.
  - EXEC: `alu_op` is driven from the latched op. At the end of the cycle, capture `alu_out` into `out_result`, update `ccr`, then go to DONE.
  - DONE: `out_valid`=1 and all `out_*` are held stable. On `out_ready`, go to IDLE.
- Outside EXEC, `alu_op`=0 and `alu_rs`/`alu_rd` hold their last latched values.
- CCR update, applied at the end of EXEC:
  - ADD: Z, N, C ← `alu_ccr`.
  - NOT: Z, N ← `alu_ccr`; C unchanged.
  - SETC: C←1, Z and N unchanged.
  - CLRC: C←0, Z and N unchanged.
  - NOP, LDM, STD, illegal: no change.
- Result flags:
  - `out_wb_en`=1 for ADD, NOT, LDM.
  - `out_mem_wr`=1 for STD only.
  - Both are 0 otherwise; `out_result` is still the captured `alu_out`.
- Arithmetic: ADD wraps modulo 2^WIDTH. The carry-out is taken from the ALU; this block does no arithmetic itself.
- `illegal` pulses in the cycle after the accept (the first EXEC cycle).

## Timing
- Reset: state=IDLE, `in_ready`=1, `out_valid`=0, `out_result`=0, `out_rd_addr`=0, `out_wb_en`=0, `out_mem_wr`=0, `ccr`=3'b000, `alu_op`=0, `alu_rs`=`alu_rd`=0, `illegal`=0.
- Accept at cycle T means EXEC at T+1 and `out_valid` at T+2.
- Minimum issue interval is 3 cycles: `in_ready` is low in EXEC and DONE, including the DONE cycle in which `out_ready` fires.
- `ccr` reflects an instruction's flag update from T+2 onward, the same cycle `out_valid` rises.
- `out_ready` held low keeps the block in DONE indefinitely with all outputs frozen. `ccr` does not change while stalled.
- `in_valid` while `in_ready`=0 is ignored; upstream must hold the instruction.
- Reset asserted in any state overrides everything: the next cycle shows reset values, and the in-flight instruction is discarded with no CCR update.

## Structure
- Shared package `alu_pkg` holds:
  - `in_op` encodings
  - ALU op codes (NOP, LDM, STD, ADD, NOT)
  - CCR bit indices Z=0, N=1, C=2
  - state enum
- `ccr_unit` is one natural sub-module: it takes the current flags, op class, `alu_ccr` and an update enable, and produces the next flags.
- The ALU is instantiated at the level above this block, not inside it.

## Test plan
- Reset, then ADD Rs=0xFFFF, Rd=0x0001, rd_addr=5 with `out_ready`=1.
  - EXEC at T+1 drives `alu_op`=3.
  - At T+2: `out_valid`=1, `out_result`=0x0000, `ccr`=3'b101, `out_wb_en`=1, `out_rd_addr`=5.
  - `in_ready` returns at T+3.
- SETC, then NOT Rd=0x00FF.
  - After SETC: `ccr`[2]=1.
  - NOT gives `out_result`=0xFF00, N=1, Z=0, and C stays 1.
- LDM imm=0x1234 with Rd=0xAAAA.
  - `alu_rd`=0x1234 in EXEC, `out_result`=0x1234, `ccr` unchanged.
- STD with Rs=0x00C3.
  - `out_mem_wr`=1, `out_wb_en`=0, `out_result`=0x00C3.
- Back-pressure: hold `out_ready`=0 for 5 cycles after `out_valid`.
  - Outputs stay frozen and `in_ready`=0 throughout.
  - A new `in_valid` is not accepted until the cycle after `out_ready`=1.
- `in_op`=9, then `rst` asserted during EXEC of an ADD.
  - `illegal` pulses once for the op=9 instruction.
  - After reset: `ccr`=0, `out_valid`=0, state IDLE.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, ALU op codes, CCR bit indices and sequencer states
package alu_pkg;
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_SETC = 4'd1;
  localparam logic [3:0] OP_CLRC = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_LDM  = 4'd5;
  localparam logic [3:0] OP_STD  = 4'd6;
  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_LDM = 3'd1;
  localparam logic [2:0] ALU_STD = 3'd2;
  localparam logic [2:0] ALU_ADD = 3'd3;
  localparam logic [2:0] ALU_NOT = 3'd4;
  localparam int CCR_Z = 0;
  localparam int CCR_N = 1;
  localparam int CCR_C = 2;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  function automatic logic [2:0] alu_op_of(input logic [3:0] op);
    return op == OP_ADD ? ALU_ADD :
           op == OP_LDM ? ALU_LDM :
           op == OP_STD ? ALU_STD :
           op == OP_NOT ? ALU_NOT : ALU_NOP;
  endfunction
endpackage

// File: rtl/ccr_unit.sv
// ccr_unit: next-state logic for the architectural Z/N/C flags
module ccr_unit
  import alu_pkg::*;
(
  input  logic [2:0] ccr_q,
  input  logic [3:0] op,
  input  logic [2:0] alu_ccr,
  input  logic       en,
  output logic [2:0] ccr_d
);
  logic zn_upd;
  assign zn_upd = en && (op == OP_ADD || op == OP_NOT);
  // Z/N follow the ALU on ADD/NOT; C follows the ALU on ADD or is forced by SETC/CLRC
  always_comb begin
    ccr_d = ccr_q;
    ccr_d[CCR_Z] = zn_upd ? alu_ccr[CCR_Z] : ccr_q[CCR_Z];
    ccr_d[CCR_N] = zn_upd ? alu_ccr[CCR_N] : ccr_q[CCR_N];
    ccr_d[CCR_C] = en && op == OP_ADD  ? alu_ccr[CCR_C] :
                   en && op == OP_SETC ? 1'b1 :
                   en && op == OP_CLRC ? 1'b0 : ccr_q[CCR_C];
  end
endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: execute-stage sequencer driving an external combinational ALU
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic [WIDTH-1:0]   in_rs_val,
  input  logic [WIDTH-1:0]   in_rd_val,
  input  logic [WIDTH-1:0]   in_imm,
  input  logic [RADDR_W-1:0] in_rd_addr,
  output logic [WIDTH-1:0]   alu_rs,
  output logic [WIDTH-1:0]   alu_rd,
  output logic [2:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic [2:0]         alu_ccr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [RADDR_W-1:0] out_rd_addr,
  output logic               out_wb_en,
  output logic               out_mem_wr,
  output logic [2:0]         ccr,
  output logic               illegal
);
  state_t state;
  logic [3:0] op_q;
  logic [RADDR_W-1:0] rd_addr_q;
  logic [2:0] ccr_d;
  ccr_unit u_ccr (
    .ccr_q   (ccr),
    .op      (op_q),
    .alu_ccr (alu_ccr),
    .en      (state == EXEC),
    .ccr_d   (ccr_d)
  );
  // Accept -> drive ALU for one cycle -> hold captured result until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      op_q        <= OP_NOP;
      rd_addr_q   <= '0;
      alu_rs      <= '0;
      alu_rd      <= '0;
      alu_op      <= ALU_NOP;
      illegal     <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_rd_addr <= '0;
      out_wb_en   <= 1'b0;
      out_mem_wr  <= 1'b0;
      ccr         <= 3'b000;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state     <= EXEC;
          in_ready  <= 1'b0;
          op_q      <= in_op;
          rd_addr_q <= in_rd_addr;
          alu_rs    <= in_rs_val;
          alu_rd    <= in_op == OP_LDM ? in_imm : in_rd_val;
          alu_op    <= alu_op_of(in_op);
          illegal   <= in_op > OP_STD;
        end
        EXEC: begin
          state       <= DONE;
          alu_op      <= ALU_NOP;
          illegal     <= 1'b0;
          out_valid   <= 1'b1;
          out_result  <= alu_out;
          out_rd_addr <= rd_addr_q;
          out_wb_en   <= op_q inside {OP_ADD, OP_NOT, OP_LDM};
          out_mem_wr  <= op_q == OP_STD;
          ccr         <= ccr_d;
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
